// File: rtl/mem_arbiter.sv
// Three-port arbiter sharing one single-port RAM: video read (0), CPU data R/W (1), CPU fetch (2).
// Optional rotating priority when ARB_ROUND_ROBIN_EN is defined; fixed priority 0 > 1 > 2 otherwise.
module mem_arbiter #(
    parameter int unsigned ADDR_W      = 15,
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned MEM_LATENCY = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [2:0]        req,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [ADDR_W-1:0] addr2,
    input  logic [DATA_W-1:0] wdata1,
    output logic [2:0]        ack,
    output logic [2:0]        gnt,
    output logic [DATA_W-1:0] rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int unsigned CNT_W = 3;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2:0]         gnt_q, gnt_d;
    logic [2:0]         ack_q, ack_d;
    logic [DATA_W-1:0]  rdata_q, rdata_d;
    logic               mem_en_q, mem_en_d;
    logic               mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]  mem_wdata_q, mem_wdata_d;
    logic [2:0]         win_oh;

`ifdef ARB_ROUND_ROBIN_EN
    // ptr_q names the port currently holding highest priority.
    logic [1:0] ptr_q, ptr_d;

    always_comb begin
        win_oh = 3'b000;
        unique case (ptr_q)
            2'd1:    win_oh = req[1] ? 3'b010 : req[2] ? 3'b100 : req[0] ? 3'b001 : 3'b000;
            2'd2:    win_oh = req[2] ? 3'b100 : req[0] ? 3'b001 : req[1] ? 3'b010 : 3'b000;
            default: win_oh = req[0] ? 3'b001 : req[1] ? 3'b010 : req[2] ? 3'b100 : 3'b000;
        endcase
    end
`else
    always_comb begin
        win_oh = req[0] ? 3'b001 : req[1] ? 3'b010 : req[2] ? 3'b100 : 3'b000;
    end
`endif

    // Next-state and registered-output logic.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        gnt_d       = gnt_q;
        ack_d       = 3'b000;
        rdata_d     = rdata_q;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
`ifdef ARB_ROUND_ROBIN_EN
        ptr_d       = ptr_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (|req) begin
                    gnt_d      = win_oh;
                    mem_en_d   = 1'b1;
                    mem_we_d   = win_oh[1] & we1;
                    mem_addr_d = win_oh[0] ? addr0 : win_oh[1] ? addr1 : addr2;
                    if (win_oh[1]) begin
                        mem_wdata_d = wdata1;
                    end
`ifdef ARB_ROUND_ROBIN_EN
                    ptr_d = win_oh[0] ? 2'd1 : win_oh[1] ? 2'd2 : 2'd0;
`endif
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (mem_we_q) begin
                    ack_d   = gnt_q;
                    state_d = ACK;
                end else begin
                    cnt_d   = CNT_W'(MEM_LATENCY - 1);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    rdata_d = mem_rdata;
                    ack_d   = gnt_q;
                    state_d = ACK;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ACK: begin
                gnt_d   = 3'b000;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            gnt_q       <= '0;
            ack_q       <= '0;
            rdata_q     <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            ptr_q       <= 2'd0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            gnt_q       <= gnt_d;
            ack_q       <= ack_d;
            rdata_q     <= rdata_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
`ifdef ARB_ROUND_ROBIN_EN
            ptr_q       <= ptr_d;
`endif
        end
    end

    assign ack       = ack_q;
    assign gnt       = gnt_q;
    assign rdata     = rdata_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule
